// File: rtl/psum_drain2x2_pkg.sv
// rtl/psum_drain2x2_pkg.sv - shared widths, FSM encoding and saturation limits for the psum drain stage
package psum_drain2x2_pkg;

    localparam int DEF_ACC_W = 26;
    localparam int DEF_OUT_W = 16;
    localparam int DEF_SH_W  = 5;

    localparam logic signed [DEF_OUT_W-1:0] OUT_MAX = 16'sh7fff;
    localparam logic signed [DEF_OUT_W-1:0] OUT_MIN = 16'sh8000;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Position of the lowest pending word; 0 when nothing is pending.
    function automatic logic [1:0] lowest_idx(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else if (m[3]) return 2'd3;
        else           return 2'd0;
    endfunction

endpackage

// File: rtl/psum_drain2x2_if.sv
// rtl/psum_drain2x2_if.sv - requantized word stream toward the output buffer
interface psum_drain2x2_if
    import psum_drain2x2_pkg::*;
#(
    parameter int OUT_W = DEF_OUT_W
);
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_data;
    logic [1:0]              out_idx;
    logic                    out_last;

    modport master (output out_valid, output out_data, output out_idx, output out_last, input out_ready);
    modport slave  (input out_valid, input out_data, input out_idx, input out_last, output out_ready);
endinterface

// File: rtl/psum_requant.sv
// rtl/psum_requant.sv - round-half-up arithmetic shift, saturation and optional ReLU of one partial sum
module psum_requant
    import psum_drain2x2_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int SH_W  = DEF_SH_W
) (
    input  logic signed [ACC_W-1:0] x,
    input  logic [SH_W-1:0]         shift,
    input  logic                    relu_en,
    output logic signed [OUT_W-1:0] r
);
    // Wide enough that neither the rounding add nor the largest rounding constant can overflow.
    localparam int W = ((ACC_W > (1 << SH_W)) ? ACC_W : (1 << SH_W)) + 2;
    localparam logic signed [W-1:0] MAX_V = (W'(1) << (OUT_W - 1)) - W'(1);
    localparam logic signed [W-1:0] MIN_V = ~MAX_V;

    logic signed [W-1:0] xe;
    logic signed [W-1:0] rnd;
    logic signed [W-1:0] sum;
    logic signed [W-1:0] shifted;

    always_comb begin
        xe  = {{(W-ACC_W){x[ACC_W-1]}}, x};
        rnd = '0;
        if (shift != '0) begin
            rnd = W'(1) << (shift - SH_W'(1));
        end
        sum     = xe + rnd;
        shifted = sum >>> shift;

        r = shifted[OUT_W-1:0];
        if (shifted > MAX_V) begin
            r = MAX_V[OUT_W-1:0];
        end else if (shifted < MIN_V) begin
            r = MIN_V[OUT_W-1:0];
        end
        if (relu_en && r[OUT_W-1]) begin
            r = '0;
        end
    end
endmodule

// File: rtl/psum_drain2x2.sv
// rtl/psum_drain2x2.sv - captures 2x2 MAC partial sums, requantizes them and streams one word per beat
module psum_drain2x2
    import psum_drain2x2_pkg::*;
#(
    parameter int ACC_W     = DEF_ACC_W,
    parameter int OUT_W     = DEF_OUT_W,
    parameter int SH_W      = DEF_SH_W,
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    drain_en,
    output logic                    drain_rdy,
    input  logic signed [ACC_W-1:0] psum0,
    input  logic signed [ACC_W-1:0] psum1,
    input  logic signed [ACC_W-1:0] psum2,
    input  logic signed [ACC_W-1:0] psum3,
    input  logic [SH_W-1:0]         shift,
    input  logic                    relu_en,
    psum_drain2x2_if.master         ob
);
    state_t                  state, state_nx;
    logic [3:0]              mask, mask_nx;
    logic [3:0]              cap_mask;
    logic                    capture;
    logic signed [OUT_W-1:0] q [4];
    logic signed [ACC_W-1:0] ps [4];
    logic signed [OUT_W-1:0] rq [4];
    logic [1:0]              idx;
    logic                    last;

    assign ps[0] = psum0;
    assign ps[1] = psum1;
    assign ps[2] = psum2;
    assign ps[3] = psum3;

    for (genvar k = 0; k < 4; k++) begin : g_rq
        psum_requant #(.ACC_W(ACC_W), .OUT_W(OUT_W), .SH_W(SH_W)) u_rq (
            .x       (ps[k]),
            .shift   (shift),
            .relu_en (relu_en),
            .r       (rq[k])
        );
        assign cap_mask[k] = SKIP_ZERO ? (rq[k] != '0) : 1'b1;
    end

    assign idx  = lowest_idx(mask);
    assign last = $onehot(mask);

    always_comb begin
        state_nx = state;
        mask_nx  = mask;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                if (drain_en) begin
                    capture  = 1'b1;
                    mask_nx  = cap_mask;
                    state_nx = (cap_mask != 4'b0000) ? SEND : IDLE;
                end
            end
            SEND: begin
                if (ob.out_ready) begin
                    mask_nx[idx] = 1'b0;
                    if (last) begin
                        state_nx = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            mask  <= 4'b0000;
            for (int k = 0; k < 4; k++) q[k] <= '0;
        end else begin
            state <= state_nx;
            mask  <= mask_nx;
            if (capture) begin
                for (int k = 0; k < 4; k++) q[k] <= rq[k];
            end
        end
    end

    // mask is cleared in IDLE, so idx/last read as 0 there and out_data shows q[0].
    assign drain_rdy    = (state == IDLE);
    assign ob.out_valid = (state == SEND);
    assign ob.out_idx   = idx;
    assign ob.out_data  = q[idx];
    assign ob.out_last  = last;
endmodule

// File: tb/tb_psum_drain2x2.sv
// tb/tb_psum_drain2x2.sv - directed vector bench for psum_drain2x2 in dense and sparse configurations
module tb_psum_drain2x2;
    import psum_drain2x2_pkg::*;

    typedef struct {
        logic signed [25:0] p0, p1, p2, p3;
        logic [4:0]         sh;
        logic               relu;
        logic signed [15:0] e0, e1, e2, e3;
    } vec_t;

    localparam int NV = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset;
    logic               d_en0, d_en1;
    logic               rdy0, rdy1;
    logic signed [25:0] p0, p1, p2, p3;
    logic [4:0]         sh;
    logic               relu;
    logic               sel;
    int                 n_cmp = 0;
    int                 n_bad = 0;
    vec_t               vecs [NV];

    psum_drain2x2_if if0 ();
    psum_drain2x2_if if1 ();

    psum_drain2x2 #(.SKIP_ZERO(1'b0)) dut0 (
        .clk(clk), .reset(reset), .drain_en(d_en0), .drain_rdy(rdy0),
        .psum0(p0), .psum1(p1), .psum2(p2), .psum3(p3),
        .shift(sh), .relu_en(relu), .ob(if0)
    );

    psum_drain2x2 #(.SKIP_ZERO(1'b1)) dut1 (
        .clk(clk), .reset(reset), .drain_en(d_en1), .drain_rdy(rdy1),
        .psum0(p0), .psum1(p1), .psum2(p2), .psum3(p3),
        .shift(sh), .relu_en(relu), .ob(if1)
    );

    logic               v_valid, v_last, v_rdy;
    logic [1:0]         v_idx;
    logic signed [15:0] v_data;
    assign v_valid = sel ? if1.out_valid : if0.out_valid;
    assign v_last  = sel ? if1.out_last  : if0.out_last;
    assign v_idx   = sel ? if1.out_idx   : if0.out_idx;
    assign v_data  = sel ? if1.out_data  : if0.out_data;
    assign v_rdy   = sel ? rdy1 : rdy0;

    function automatic vec_t mk(input int a, input int b, input int c, input int d,
                                input int s, input bit r,
                                input int x0, input int x1, input int x2, input int x3);
        mk.p0 = 26'(a); mk.p1 = 26'(b); mk.p2 = 26'(c); mk.p3 = 26'(d);
        mk.sh = 5'(s);  mk.relu = r;
        mk.e0 = 16'(x0); mk.e1 = 16'(x1); mk.e2 = 16'(x2); mk.e3 = 16'(x3);
    endfunction

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic load(input vec_t v);
        p0 = v.p0; p1 = v.p1; p2 = v.p2; p3 = v.p3;
        sh = v.sh; relu = v.relu;
    endtask

    // One tile: capture, then expect one beat per cycle (ready held high), then idle.
    task automatic run_vec(input bit s, input vec_t v, input string tag);
        int e [4];
        int eidx [4];
        int n;
        sel = s;
        load(v);
        if (s) d_en1 = 1'b1; else d_en0 = 1'b1;
        @(negedge clk);
        d_en0 = 1'b0;
        d_en1 = 1'b0;
        e[0] = v.e0; e[1] = v.e1; e[2] = v.e2; e[3] = v.e3;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            if (!s || e[k] != 0) begin
                eidx[n] = k;
                n++;
            end
        end
        for (int b = 0; b < n; b++) begin
            chk({tag, "/valid"}, 32'(v_valid), 1);
            chk({tag, "/idx"},   32'(v_idx), eidx[b]);
            chk({tag, "/data"},  32'(v_data), e[eidx[b]]);
            chk({tag, "/last"},  32'(v_last), (b == n - 1) ? 1 : 0);
            @(negedge clk);
        end
        chk({tag, "/end_valid"}, 32'(v_valid), 0);
        chk({tag, "/end_rdy"},   32'(v_rdy), 1);
    endtask

    initial begin
        vecs[0] = mk(384, -384, 0, 128, 8, 1'b0, 2, -1, 0, 1);
        vecs[1] = mk(1 << 24, 0, 0, 0, 4, 1'b0, int'(OUT_MAX), 0, 0, 0);
        vecs[2] = mk(-(1 << 25), (1 << 25) - 1, 5, -5, 0, 1'b0, int'(OUT_MIN), int'(OUT_MAX), 5, -5);
        vecs[3] = mk(-384, 384, -1, 0, 8, 1'b1, 0, 2, 0, 0);
        vecs[4] = mk(3, -3, 1, -1, 1, 1'b0, 2, -1, 1, 0);
        vecs[5] = mk(-(1 << 25), (1 << 25) - 1, 100, -100, 31, 1'b0, 0, 0, 0, 0);
        vecs[6] = mk((1 << 25) - 1, -(1 << 25), 32767, -524288, 20, 1'b0, 32, -32, 0, 0);
        vecs[7] = mk(-16777216, 524272, 524280, -524296, 4, 1'b0, -32768, 32767, 32767, -32768);
        vecs[8] = mk(0, 7, 0, -5, 0, 1'b0, 0, 7, 0, -5);
        vecs[9] = mk(0, 0, 0, 0, 0, 1'b0, 0, 0, 0, 0);

        reset = 1'b1;
        d_en0 = 1'b0; d_en1 = 1'b0;
        p0 = '0; p1 = '0; p2 = '0; p3 = '0; sh = '0; relu = 1'b0;
        sel = 1'b0;
        if0.out_ready = 1'b1;
        if1.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst/valid", 32'(if0.out_valid), 0);
        chk("rst/data",  32'(if0.out_data), 0);
        chk("rst/idx",   32'(if0.out_idx), 0);
        chk("rst/last",  32'(if0.out_last), 0);
        chk("rst/rdy0",  32'(rdy0), 1);
        chk("rst/rdy1",  32'(rdy1), 1);
        reset = 1'b0;
        @(negedge clk);

        // Tiles run back to back: each capture lands the cycle after the previous last beat.
        for (int i = 0; i < NV; i++) run_vec(1'b0, vecs[i], $sformatf("dense%0d", i));
        for (int i = 0; i < NV; i++) run_vec(1'b1, vecs[i], $sformatf("sparse%0d", i));

        sel = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("zero_tile/valid", 32'(v_valid), 0);
            chk("zero_tile/rdy",   32'(v_rdy), 1);
        end

        // Backpressure on the second beat with a stray drain_en.
        sel = 1'b0;
        load(vecs[0]);
        d_en0 = 1'b1;
        @(negedge clk);
        d_en0 = 1'b0;
        chk("bp/first_idx", 32'(v_idx), 0);
        @(negedge clk);
        if0.out_ready = 1'b0;
        load(vecs[7]);
        d_en0 = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            d_en0 = 1'b0;
            chk("bp/valid", 32'(v_valid), 1);
            chk("bp/idx",   32'(v_idx), 1);
            chk("bp/data",  32'(v_data), -1);
            chk("bp/last",  32'(v_last), 0);
            chk("bp/rdy",   32'(v_rdy), 0);
        end
        if0.out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            chk("bp/rest_idx",  32'(v_idx), k);
            chk("bp/rest_data", 32'(v_data), (k == 1) ? -1 : (k == 2) ? 0 : 1);
            chk("bp/rest_last", 32'(v_last), (k == 3) ? 1 : 0);
            @(negedge clk);
        end
        chk("bp/end_valid", 32'(v_valid), 0);
        @(negedge clk);
        chk("bp/no_extra", 32'(v_valid), 0);

        // Reset while the second beat is presented.
        load(vecs[2]);
        d_en0 = 1'b1;
        @(negedge clk);
        d_en0 = 1'b0;
        chk("mrst/first_idx", 32'(v_idx), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mrst/valid", 32'(v_valid), 0);
        chk("mrst/rdy",   32'(v_rdy), 1);
        chk("mrst/idx",   32'(v_idx), 0);
        chk("mrst/data",  32'(v_data), 0);
        chk("mrst/last",  32'(v_last), 0);
        run_vec(1'b0, vecs[0], "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
